uart_ctrl_gen2: RTL and testbench
=================================

# uart_ctrl_gen2

Second-generation UART controller for the CPU's memory-mapped I/O path, connecting the core-side byte interface to the serial Tx/Rx pins. Compared with the first-generation block it adds parametrised data width, FIFO depth, parity mode and stop-bit count. It also adds 16x oversampling with majority-vote sampling, a metastability synchroniser on Rx, and per-byte parity/framing error reporting plus a sticky overrun flag. Both directions are buffered by internal FIFOs; the core pushes and pops single words with one-cycle strobes.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9, LSB first on the wire.
- FIFO_DEPTH, 16: entries per FIFO, power of two, >= 2.
- CLK_RATE, 100000000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate. Oversample divisor DIV = CLK_RATE/(BAUD_RATE*16), integer-truncated, must be >= 2.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- send_flag  in  1  push send_data into the Tx FIFO this cycle; ignored when send_able = 0.
- send_data  in  DATA_BITS  word to transmit.
- send_able  out  1  Tx FIFO not full.
- recv_flag  in  1  pop the Rx FIFO head this cycle; ignored when recv_able = 0.
- recv_data  out  DATA_BITS  Rx FIFO head (show-ahead); valid while recv_able = 1.
- recv_able  out  1  Rx FIFO not empty.
- recv_err  out  3  {overrun, frame_err, parity_err}. Bits 1:0 belong to the head entry; bit 2 is sticky.
- err_clr  in  1  clears the sticky overrun bit.
- Tx  out  1  serial out, idles high.
- Rx  in  1  serial in, asynchronous.

## Operation
- Reset values: Tx = 1, send_able = 1, recv_able = 0, recv_data = 0, recv_err = 0. Both FIFOs are emptied and both FSMs return to IDLE. Asserting rst mid-frame aborts the frame immediately: Tx goes to 1 and any partial Rx word is discarded.
- FIFOs:
  - Each Rx entry is DATA_BITS+2 wide (data, frame_err, parity_err).
  - A simultaneous push and pop is legal in every fill state, including full with a pop and empty with a push; occupancy then stays the same.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Tick generator: free-running counter 0..DIV-1. It asserts a 1-cycle tick when the count is DIV-1.
- Rx path:
  - Rx is passed through a 2-FF synchroniser, giving rxs; rxs lags Rx by 2 cycles.
  - The 4-bit phase counter advances on each tick.
  - IDLE -> START when rxs = 0 is seen on a tick; phase is reset to 0.
  - At phase 7, 8 and 9 the block samples rxs and takes a 2-of-3 majority vote. The decision is made at phase 9.
  - START: a majority of 1 is a glitch and returns the FSM to IDLE. A majority of 0 moves to DATA.
  - DATA: collects DATA_BITS bits, LSB first, then moves to PARITY, or to STOP if PARITY = 0.
  - PARITY: parity_err = 1 if (XOR of data bits ^ received bit) differs from the expected value: 0 for even, 1 for odd.
  - STOP: only the first stop bit is checked, even when STOP_BITS = 2. frame_err = 1 if that bit's majority is 0.
  - At the phase-9 decision of STOP, the word and its flags are pushed in the same cycle. They are pushed if the Rx FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the word is dropped and overrun is set.
  - After the STOP decision the FSM enters WAIT_HIGH and re-arms to IDLE only once rxs = 1. This prevents a line break from producing repeated frames.
- Overrun: set on a drop and cleared by err_clr. If a set and err_clr occur in the same cycle, the set wins.
- Tx path:
  - IDLE: when the Tx FIFO is not empty, pop it, latch the word, drive Tx = 0 on the next cycle and enter START.
  - Each bit is held for exactly 16*DIV clk cycles, using a local counter.
  - Bit order: START, then DATA (LSB first), then PARITY if enabled, then STOP_BITS stop bits at 1, then back to IDLE.
  - A new frame may start on the cycle immediately after the last stop bit completes (back-to-back).
- Behaviour at the boundaries:
  - A push when full does not change FIFO contents.
  - A pop when empty leaves recv_data unchanged.
  - recv_err[1:0] reads 0 whenever recv_able = 0.

## Timing
- send_flag accepted at cycle t, Tx FIFO previously empty and Tx FSM idle: Tx falls at t+2.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * 16 * DIV cycles.
- recv_able rises 1 cycle after the STOP decision, when the registered FIFO write becomes visible.
- recv_flag at cycle t: the next entry appears on recv_data at t+1.
- send_able falls on the cycle after the push that fills the FIFO.
- Rx tolerates ±3% baud mismatch at DIV >= 4.

## Test plan
- Loopback (Tx tied to Rx), DATA_BITS = 8, PARITY = 1, DIV = 4: push 0xA5, 0x3C and 0xFF back-to-back. recv_data yields the same sequence with recv_err = 0. Each frame is 11*64 = 704 cycles.
- Odd parity, externally driven frame for 0x01 with the parity bit forced to 1 (should be 0): the entry is 0x01 with recv_err = 3'b001.
- Stop bit driven 0 for one bit time, then high: the entry has frame_err = 1. Exactly one word is received, and the receiver re-arms after Rx returns high.
- Rx pulse of 4 cycles low (shorter than 8 ticks): no word is received and recv_able stays 0.
- FIFO_DEPTH = 4: receive 5 frames without popping. recv_able = 1, the 4 oldest words are intact and recv_err[2] = 1. Pulse err_clr: bit 2 clears.
- Assert rst mid-transmission of 0x55: Tx = 1 within the same cycle, send_able = 1, and nothing further is transmitted.

Source files
------------

// File: rtl/uart_ctrl_gen2_if.sv
// Core-side word interface of uart_ctrl_gen2: single-cycle push/pop strobes with status flags.
// The master side is the CPU I/O path; the slave side is the UART.
interface uart_ctrl_gen2_if #(parameter int DATA_BITS = 8);
  logic                 send_flag;
  logic [DATA_BITS-1:0] send_data;
  logic                 send_able;
  logic                 recv_flag;
  logic [DATA_BITS-1:0] recv_data;
  logic                 recv_able;
  logic [2:0]           recv_err;
  logic                 err_clr;

  modport master (
    output send_flag, send_data, recv_flag, err_clr,
    input  send_able, recv_data, recv_able, recv_err
  );

  modport slave (
    input  send_flag, send_data, recv_flag, err_clr,
    output send_able, recv_data, recv_able, recv_err
  );
endinterface

// File: rtl/uart_ctrl_gen2.sv
// UART with Tx/Rx FIFOs, 16x oversampled majority-vote receiver, parity/framing/overrun flags.
// Tx falls 2 cycles after a push into an idle path; pushes when full and pops when empty are ignored.

// Show-ahead FIFO; push while full is accepted only alongside a pop.
module uart_ctrl_gen2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module uart_ctrl_gen2 #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_ctrl_gen2_if.slave   bus,
  output logic              Tx,
  input  logic              Rx
);
  localparam int DIV     = CLK_RATE / (BAUD_RATE * 16);
  localparam int BIT_CYC = 16 * DIV;
  localparam int BCW     = $clog2(BIT_CYC);
  localparam int DCW     = $clog2(DIV);
  localparam bit ODD     = (PARITY == 2);

  // ---------------- Tx path ----------------
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_dout, tx_shreg;
  logic                 tx_full, tx_empty, tx_pop, tx_par, tx_last;
  logic [BCW-1:0]       tx_cnt;
  logic [3:0]           tx_idx;

  assign tx_last = (tx_cnt == BCW'(BIT_CYC - 1));
  // Pop on idle, or straight out of the final stop bit for back-to-back frames.
  assign tx_pop  = !tx_empty && ((tx_state == T_IDLE) ||
                   (tx_state == T_STOP && tx_last && tx_idx == 4'(STOP_BITS - 1)));
  assign bus.send_able = !tx_full;

  uart_ctrl_gen2_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk, .rst, .push(bus.send_flag), .pop(tx_pop), .din(bus.send_data),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      Tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= T_START;
      Tx       <= 1'b0;
      tx_cnt   <= '0;
      tx_shreg <= tx_dout;
      tx_par   <= (^tx_dout) ^ ODD;
    end else if (tx_state != T_IDLE) begin
      tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
      if (tx_last) begin
        case (tx_state)
          T_START: begin
            Tx       <= tx_shreg[0];
            tx_idx   <= '0;
            tx_state <= T_DATA;
          end
          T_DATA: begin
            if (tx_idx == 4'(DATA_BITS - 1)) begin
              Tx       <= (PARITY != 0) ? tx_par : 1'b1;
              tx_idx   <= '0;
              tx_state <= (PARITY != 0) ? T_PAR : T_STOP;
            end else begin
              Tx       <= tx_shreg[1];
              tx_shreg <= tx_shreg >> 1;
              tx_idx   <= tx_idx + 1'b1;
            end
          end
          T_PAR: begin
            Tx       <= 1'b1;
            tx_state <= T_STOP;
          end
          default: begin
            if (tx_idx == 4'(STOP_BITS - 1)) begin
              Tx       <= 1'b1;
              tx_state <= T_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- Rx path ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

  rx_state_t            rx_state;
  logic                 rx_meta, rxs, tick, s7, s8, maj, decide;
  logic [DCW-1:0]       div_cnt;
  logic [3:0]           phase, rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_err, rx_push, rx_full, rx_empty, rx_drop, overrun;
  logic [DATA_BITS+1:0] rx_dout;

  assign tick    = (div_cnt == DCW'(DIV - 1));
  assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign decide  = tick && (phase == 4'd9);
  assign rx_push = decide && (rx_state == R_STOP);
  // When full, the pop strobe is effective, so it alone decides whether the word fits.
  assign rx_drop = rx_push && rx_full && !bus.recv_flag;

  uart_ctrl_gen2_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk, .rst, .push(rx_push), .pop(bus.recv_flag), .din({rx_shreg, ~maj, rx_par_err}),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign bus.recv_able = !rx_empty;
  assign bus.recv_data = rx_empty ? '0 : rx_dout[DATA_BITS+1:2];
  assign bus.recv_err  = {overrun, rx_empty ? 2'b00 : rx_dout[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      div_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (rx_drop)          overrun <= 1'b1;
      else if (bus.err_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= R_IDLE;
      phase      <= '0;
      rx_idx     <= '0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      rx_shreg   <= '0;
      rx_par_err <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: if (tick && !rxs) begin
          rx_state <= R_START;
          phase    <= '0;
        end
        R_WAIT: if (rxs) rx_state <= R_IDLE;
        default: if (tick) begin
          phase <= phase + 1'b1;
          if (phase == 4'd7) s7 <= rxs;
          if (phase == 4'd8) s8 <= rxs;
          if (decide) begin
            case (rx_state)
              R_START: begin
                rx_state   <= maj ? R_IDLE : R_DATA;
                rx_idx     <= '0;
                rx_par_err <= 1'b0;
              end
              R_DATA: begin
                rx_shreg <= {maj, rx_shreg[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 1'b1;
                if (rx_idx == 4'(DATA_BITS - 1))
                  rx_state <= (PARITY != 0) ? R_PAR : R_STOP;
              end
              R_PAR: begin
                rx_par_err <= ((^rx_shreg) ^ maj) != ODD;
                rx_state   <= R_STOP;
              end
              default: rx_state <= R_WAIT;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ctrl_gen2.sv
// Directed bench for uart_ctrl_gen2: u0 even parity/depth 16 (loopback capable), u1 odd parity/depth 4.
module tb_uart_ctrl_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_ctrl_gen2_if #(.DATA_BITS(8)) b0 ();
  uart_ctrl_gen2_if #(.DATA_BITS(8)) b1 ();

  logic tx0, tx1, rx0, rx1;
  logic rx0_drv = 1'b1;
  logic rx1_drv = 1'b1;
  logic loop_en = 1'b0;
  assign rx0 = loop_en ? tx0 : rx0_drv;
  assign rx1 = rx1_drv;

  // CLK_RATE/(BAUD_RATE*16) = 640/160 = 4, so one bit is 64 cycles.
  uart_ctrl_gen2 #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLK_RATE(640), .BAUD_RATE(10),
                   .PARITY(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .Tx(tx0), .Rx(rx0));
  uart_ctrl_gen2 #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_RATE(640), .BAUD_RATE(10),
                   .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .Tx(tx1), .Rx(rx1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0_drv = v;
    else            rx1_drv = v;
  endtask

  task automatic hold_bit(input int which, input logic v);
    set_rx(which, v);
    repeat (64) @(negedge clk);
  endtask

  // start, 8 data LSB first, parity, stop, then one idle bit time
  task automatic drive_frame(input int which, input logic [7:0] d, input logic par, input logic stp);
    hold_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(which, d[i]);
    hold_bit(which, par);
    hold_bit(which, stp);
    hold_bit(which, 1'b1);
  endtask

  task automatic pop_check(input int which, input string tag, input logic [7:0] ed, input logic [2:0] ee);
    @(negedge clk);
    if (which == 0) begin
      check({tag, "_data"}, 32'(b0.recv_data), 32'(ed));
      check({tag, "_err"},  32'(b0.recv_err),  32'(ee));
      b0.recv_flag = 1'b1;
      @(negedge clk);
      b0.recv_flag = 1'b0;
    end else begin
      check({tag, "_data"}, 32'(b1.recv_data), 32'(ed));
      check({tag, "_err"},  32'(b1.recv_err),  32'(ee));
      b1.recv_flag = 1'b1;
      @(negedge clk);
      b1.recv_flag = 1'b0;
    end
  endtask

  initial begin
    int lows;
    b0.send_flag = 1'b0; b0.send_data = '0; b0.recv_flag = 1'b0; b0.err_clr = 1'b0;
    b1.send_flag = 1'b0; b1.send_data = '0; b1.recv_flag = 1'b0; b1.err_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx",        32'(tx0),          32'd1);
    check("rst_send_able", 32'(b0.send_able), 32'd1);
    check("rst_recv_able", 32'(b0.recv_able), 32'd0);
    check("rst_recv_data", 32'(b0.recv_data), 32'd0);
    check("rst_recv_err",  32'(b0.recv_err),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pop on empty FIFO is ignored
    b0.recv_flag = 1'b1;
    @(negedge clk);
    b0.recv_flag = 1'b0;
    check("empty_pop_data", 32'(b0.recv_data), 32'd0);
    check("empty_pop_able", 32'(b0.recv_able), 32'd0);

    // u1 Tx FIFO: one word is taken by the Tx FSM, four more fill it, the sixth is ignored
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) check("send_able_not_full", 32'(b1.send_able), 32'd1);
      if (i == 5) check("send_able_full",     32'(b1.send_able), 32'd0);
      b1.send_flag = 1'b1;
      b1.send_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    b1.send_flag = 1'b0;
    check("send_able_after_ovf_push", 32'(b1.send_able), 32'd0);

    // 4-cycle low glitch on Rx
    rx0_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx0_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_word", 32'(b0.recv_able), 32'd0);

    // 0x5A even parity bit 0, stop bit held low for one bit time
    drive_frame(0, 8'h5A, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_avail", 32'(b0.recv_able), 32'd1);
    pop_check(0, "frame_err", 8'h5A, 3'b010);
    check("frame_err_single", 32'(b0.recv_able), 32'd0);

    // Odd parity: 0x01 needs parity 0, driven 1
    drive_frame(1, 8'h01, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    pop_check(1, "odd_par", 8'h01, 3'b001);
    check("odd_par_single", 32'(b1.recv_able), 32'd0);

    // Overrun: 5 frames into depth-4 FIFO; each word has an even bit count so odd parity bit = 1
    drive_frame(1, 8'h11, 1'b1, 1'b1);
    drive_frame(1, 8'h22, 1'b1, 1'b1);
    drive_frame(1, 8'h33, 1'b1, 1'b1);
    drive_frame(1, 8'h44, 1'b1, 1'b1);
    drive_frame(1, 8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_able", 32'(b1.recv_able), 32'd1);
    pop_check(1, "ovr_w0", 8'h11, 3'b100);
    pop_check(1, "ovr_w1", 8'h22, 3'b100);
    pop_check(1, "ovr_w2", 8'h33, 3'b100);
    pop_check(1, "ovr_w3", 8'h44, 3'b100);
    check("ovr_drained",      32'(b1.recv_able), 32'd0);
    check("ovr_sticky_empty", 32'(b1.recv_err),  32'b100);
    b1.err_clr = 1'b1;
    @(negedge clk);
    b1.err_clr = 1'b0;
    check("ovr_cleared", 32'(b1.recv_err), 32'd0);

    // Loopback on u0: three back-to-back frames
    loop_en = 1'b1;
    @(negedge clk);
    b0.send_flag = 1'b1; b0.send_data = 8'hA5;
    @(negedge clk);
    check("tx_latency_t1", 32'(tx0), 32'd1);
    b0.send_data = 8'h3C;
    @(negedge clk);
    check("tx_latency_t2", 32'(tx0), 32'd0);
    b0.send_data = 8'hFF;
    @(negedge clk);
    b0.send_flag = 1'b0;
    repeat (702) @(negedge clk);
    check("frame1_last_stop", 32'(tx0), 32'd1);
    @(negedge clk);
    check("frame2_start", 32'(tx0), 32'd0);
    repeat (2 * 704 + 50) @(negedge clk);
    pop_check(0, "loop_a5", 8'hA5, 3'b000);
    pop_check(0, "loop_3c", 8'h3C, 3'b000);
    pop_check(0, "loop_ff", 8'hFF, 3'b000);
    check("loop_drained", 32'(b0.recv_able), 32'd0);

    // Reset in the start bit of 0x55
    @(negedge clk);
    b0.send_flag = 1'b1; b0.send_data = 8'h55;
    @(negedge clk);
    b0.send_flag = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx0), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_tx",        32'(tx0),          32'd1);
    check("rst_mid_send_able", 32'(b0.send_able), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (tx0 == 1'b0) lows++;
    end
    check("rst_no_retx", 32'(lows), 32'd0);
    check("rst_no_rx",   32'(b0.recv_able), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
